// File: rtl/aes_ks_pkg.sv
// Shared types and helpers for the multi-length AES key expander.
package aes_ks_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NW_MAX = 60;

    typedef enum logic [1:0] {
        AES128      = 2'b00,
        AES192      = 2'b01,
        AES256      = 2'b10,
        KEY_ILLEGAL = 2'b11
    } keylen_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    // Key length in 32-bit words; 0 marks an illegal selector.
    function automatic logic [3:0] nk_of(input keylen_t kl);
        case (kl)
            AES128:  return 4'd4;
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input keylen_t kl);
        logic [3:0] nk;
        nk = nk_of(kl);
        return (nk == 4'd0) ? 4'd0 : 4'(nk + 4'd6);
    endfunction

    // Total schedule length in words.
    function automatic logic [5:0] nw_of(input keylen_t kl);
        logic [3:0] nr;
        nr = nr_of(kl);
        return (nr == 4'd0) ? 6'd0 : 6'({nr, 2'b00} + 6'd4);
    endfunction

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_multi_sbox.sv
// Four parallel forward AES S-boxes (SubWord), purely combinational.
//   word  : 32-bit input word
//   sub_c : byte-wise S-box substitution of word
module aes_sbox_word
    import aes_ks_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_c
);

    // Byte b lives at bits [8*(255-b) +: 8], i.e. entry 0 is the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    always_comb begin
        sub_c = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes_key_expand_multi.sv
// AES-128/192/256 key expander: one schedule word per cycle into a 60-word
// round-key store with a random-access 128-bit round-key read port.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, keylen_i,
//   key_i               : job request (key MSB-aligned, w0 = key_i[255:224])
//   busy_o, done_o,
//   valid_o, err_o      : job status (done_o/err_o are one-cycle pulses)
//   nr_o                : round count of the current schedule, 0 after reset
//   rd_round_i, rd_key_o: round-key read port (RD_REG selects 1-cycle latency)
module aes_key_expand_multi
    import aes_ks_pkg::*;
#(
    parameter int unsigned MAX_NK = 8,
    parameter bit          RD_REG = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       keylen_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [3:0]       nr_o,
    input  logic [3:0]       rd_round_i,
    output logic [BLK_W-1:0] rd_key_o
);

    state_t              state_q, state_d;
    keylen_t             kl_q;
    logic [KEY_W-1:0]    key_q;
    logic [KEY_W-1:0]    win_q;   // sliding window, w[i-1] in the low word
    logic [5:0]          idx_q;   // index i of the word being produced
    logic [2:0]          mod_q;   // i mod Nk
    logic [7:0]          rcon_q;
    logic [WORD_W-1:0]   store [NW_MAX];

    logic                accept, busy_d, done_d, valid_d, err_d;
    logic [3:0]          req_nk, nk_q;
    logic [5:0]          nw_q;
    logic [2:0]          mod_nxt;
    logic [WORD_W-1:0]   prev_w, old_w, sub_in, sub_out, tmp_w, new_w;
    logic [5:0]          rd_base;
    logic                rd_ok;
    logic [BLK_W-1:0]    rd_key_c;

    aes_sbox_word u_sbox (
        .word  (sub_in),
        .sub_c (sub_out)
    );

    // Next state and next registered-output values.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = valid_o;
        req_nk  = nk_of(keylen_t'(keylen_i));
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (keylen_i == 2'b11 || 32'(req_nk) > MAX_NK) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = LOAD;
                        busy_d  = 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                state_d = EXPAND;
                busy_d  = 1'b1;
            end
            EXPAND: begin
                if (idx_q == 6'(nw_q - 6'd1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            nr_o    <= 4'd0;
        end else begin
            state_q <= state_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            valid_o <= valid_d;
            err_o   <= err_d;
            if (state_q == LOAD) begin
                nr_o <= nr_of(kl_q);
            end
        end
    end

    // Next schedule word from the window.
    always_comb begin
        nk_q    = nk_of(kl_q);
        nw_q    = nw_of(kl_q);
        prev_w  = win_q[31:0];
        case (kl_q)
            AES128:  old_w = win_q[127:96];
            AES192:  old_w = win_q[191:160];
            default: old_w = win_q[255:224];
        endcase
        sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        tmp_w   = prev_w;
        if (mod_q == 3'd0) begin
            tmp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (kl_q == AES256 && mod_q == 3'd4) begin
            tmp_w = sub_out;
        end
        new_w   = old_w ^ tmp_w;
        mod_nxt = (4'(mod_q) + 4'd1 == nk_q) ? 3'd0 : 3'(mod_q + 3'd1);
    end

    // Job parameters, window and counters.
    always_ff @(posedge clk_i) begin
        case (state_q)
            IDLE: begin
                if (accept) begin
                    kl_q  <= keylen_t'(keylen_i);
                    key_q <= key_i;
                end
            end
            LOAD: begin
                // Right-align the key so w[Nk-1] lands in the low word.
                case (kl_q)
                    AES128:  win_q <= key_q >> 128;
                    AES192:  win_q <= key_q >> 64;
                    default: win_q <= key_q;
                endcase
                idx_q  <= 6'(nk_q);
                mod_q  <= 3'd0;
                rcon_q <= 8'h01;
            end
            EXPAND: begin
                win_q <= {win_q[KEY_W-WORD_W-1:0], new_w};
                idx_q <= 6'(idx_q + 6'd1);
                mod_q <= mod_nxt;
                if (mod_q == 3'd0) begin
                    rcon_q <= xtime(rcon_q);
                end
            end
            default: ;
        endcase
    end

    // Round-key store; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == LOAD) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(nk_q)) begin
                        store[j] <= key_q[KEY_W-1-32*j -: 32];
                    end
                end
            end else if (state_q == EXPAND) begin
                store[idx_q] <= new_w;
            end
        end
    end

    // Asynchronous read of four consecutive words.
    always_comb begin
        rd_base  = {rd_round_i, 2'b00};
        rd_ok    = (nr_o != 4'd0) && (rd_round_i <= nr_o);
        rd_key_c = '0;
        if (rd_ok) begin
            rd_key_c = {store[rd_base], store[6'(rd_base + 6'd1)],
                        store[6'(rd_base + 6'd2)], store[6'(rd_base + 6'd3)]};
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [BLK_W-1:0] rd_key_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_key_q <= '0;
                end else begin
                    rd_key_q <= rd_key_c;
                end
            end
            assign rd_key_o = rd_key_q;
        end else begin : g_rd_comb
            assign rd_key_o = rd_key_c;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Scoreboard bench for aes_key_expand_multi using FIPS-197 Appendix A vectors.
module tb_aes_key_expand_multi;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   keylen_i = 2'b00;
    logic [255:0] key_i = '0;
    logic         busy_o, done_o, valid_o, err_o;
    logic [3:0]   nr_o;
    logic [3:0]   rd_round_i = 4'd0;
    logic [127:0] rd_key_o;

    logic         start4 = 1'b0;
    logic [1:0]   keylen4 = 2'b00;
    logic         busy4, done4, valid4, err4;
    logic [3:0]   nr4;
    logic [127:0] rd_key4;

    always #5 clk = ~clk;

    aes_key_expand_multi #(.MAX_NK(8), .RD_REG(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .keylen_i(keylen_i),
        .key_i(key_i), .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o),
        .err_o(err_o), .nr_o(nr_o), .rd_round_i(rd_round_i), .rd_key_o(rd_key_o)
    );

    aes_key_expand_multi #(.MAX_NK(4), .RD_REG(1'b1)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start4), .keylen_i(keylen4),
        .key_i(key_i), .busy_o(busy4), .done_o(done4), .valid_o(valid4),
        .err_o(err4), .nr_o(nr4), .rd_round_i(4'd0), .rd_key_o(rd_key4)
    );

    typedef struct {
        bit is_err;
        int due;
    } evt_t;

    evt_t         evq[$];
    logic [127:0] rdq[$];
    evt_t         ev;
    logic [127:0] rexp;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         rd_pend = 1'b0;
    logic         rd_pend_d = 1'b0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_pend_d <= rd_pend;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected pulses and read data as the DUT presents them.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (done_o || err_o) begin
                if (evq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b at interval %0d", done_o, err_o, cyc + 1);
                end else begin
                    ev = evq.pop_front();
                    chk("pulse_kind_err", 128'(err_o), 128'(ev.is_err));
                    chk("pulse_kind_done", 128'(done_o), 128'(!ev.is_err));
                    chk("pulse_interval", 128'(cyc + 1), 128'(ev.due));
                end
            end
            if (rd_pend_d) begin
                if (rdq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL read_underflow: got %h want none", rd_key_o);
                end else begin
                    rexp = rdq.pop_front();
                    chk("rd_key", rd_key_o, rexp);
                end
            end
        end
    end

    task automatic rd(input logic [3:0] r, input logic [127:0] exp);
        @(negedge clk);
        rd_round_i = r;
        rd_pend    = 1'b1;
        rdq.push_back(exp);
        @(negedge clk);
        rd_pend = 1'b0;
    endtask

    // Start a job; done_o is due in interval k+2+(Nw-Nk) after accept edge k.
    task automatic run_job(input logic [1:0] kl, input logic [255:0] k, input bit hold);
        int nk, nw, t;
        nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        nw = 4 * (nk + 7);
        @(negedge clk);
        start_i  = 1'b1;
        keylen_i = kl;
        key_i    = k;
        evq.push_back('{1'b0, cyc + 3 + nw - nk});
        @(negedge clk);
        if (!hold) start_i = 1'b0;
        chk("load_busy", 128'(busy_o), 128'(1));
        chk("load_valid", 128'(valid_o), 128'(0));
        t = 0;
        while (!done_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done_o want done_o within 200 cycles");
        end
        start_i = 1'b0;
        chk("done_valid", 128'(valid_o), 128'(1));
        chk("done_busy", 128'(busy_o), 128'(0));
        chk("done_nr", 128'(nr_o), 128'(nk + 6));
        @(negedge clk);
        chk("post_done_busy", 128'(busy_o), 128'(0));
    endtask

    task automatic bad_start(input logic [1:0] kl, input logic exp_valid);
        @(negedge clk);
        start_i  = 1'b1;
        keylen_i = kl;
        evq.push_back('{1'b1, cyc + 2});
        @(negedge clk);
        start_i = 1'b0;
        chk("err_busy", 128'(busy_o), 128'(0));
        chk("err_valid", 128'(valid_o), 128'(exp_valid));
        @(negedge clk);
        chk("err_single", 128'(err_o), 128'(0));
        chk("err_idle_busy", 128'(busy_o), 128'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_nr", 128'(nr_o), 128'(0));
        chk("rst_rdkey", rd_key_o, 128'h0);
        rst_i = 1'b0;
        rd(4'd0, 128'h0);

        // AES-128 with start held high for the whole job.
        run_job(2'b00, K128, 1'b1);
        rd(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd2, 128'hf2c295f27a96b9435935807a7359f67f);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd11, 128'h0);

        // AES-192 started while valid_o=1.
        run_job(2'b01, K192, 1'b0);
        rd(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13, 128'h0);

        // AES-256.
        run_job(2'b10, K256, 1'b0);
        rd(4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
        rd(4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd15, 128'h0);

        // Illegal key length leaves the valid schedule in place.
        bad_start(2'b11, 1'b1);
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

        // MAX_NK=4 instance rejects AES-256 and accepts AES-128.
        @(negedge clk);
        start4  = 1'b1;
        keylen4 = 2'b10;
        @(negedge clk);
        start4 = 1'b0;
        chk("max4_err", 128'(err4), 128'(1));
        chk("max4_busy", 128'(busy4), 128'(0));
        @(negedge clk);
        chk("max4_err_single", 128'(err4), 128'(0));
        start4  = 1'b1;
        keylen4 = 2'b00;
        @(negedge clk);
        start4 = 1'b0;
        chk("max4_accept_busy", 128'(busy4), 128'(1));
        chk("max4_accept_err", 128'(err4), 128'(0));

        // Reset during EXPAND cycle 20 aborts with no done_o.
        @(negedge clk);
        start_i  = 1'b1;
        keylen_i = 2'b00;
        key_i    = K128;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_abort_busy", 128'(busy_o), 128'(1));
        rst_i = 1'b1;
        @(negedge clk);
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_valid", 128'(valid_o), 128'(0));
        chk("abort_nr", 128'(nr_o), 128'(0));
        chk("abort_done", 128'(done_o), 128'(0));
        rst_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", 128'(busy_o), 128'(0));
        rd(4'd0, 128'h0);

        // Fresh AES-128 job after the abort.
        run_job(2'b00, K128, 1'b0);
        rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (5) @(negedge clk);
        chk("pulses_outstanding", 128'(evq.size()), 128'(0));
        chk("reads_outstanding", 128'(rdq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_multi.md
Name: aes_key_expand_multi

Overview:
Parametrised AES key expander supporting AES-128/192/256, selected per job. Generates the full FIPS-197 round-key schedule, one 32-bit word per cycle, into an internal round-key store. The round datapath reads any round key by index via a random-access read port. Successor to the fixed-width key schedule; feeds the AES round core in the crypto extension.

Parameters:
MAX_NK, 8, largest key length in words; legal values 4, 6 or 8; key lengths above MAX_NK are rejected.
RD_REG, 1, 1 = registered read port (1-cycle latency), 0 = combinational read.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start request; accepted only in IDLE
keylen_i  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal; sampled with start_i
key_i  in  256  cipher key, MSB-aligned; w0 = key_i[255:224]; unused LSBs ignored
busy_o  out  1  high in LOAD and EXPAND
done_o  out  1  one-cycle pulse when the schedule is complete
valid_o  out  1  level; the store holds a complete schedule for the last accepted key
err_o  out  1  one-cycle pulse on a rejected start
nr_o  out  4  Nr of the current schedule (10/12/14); 0 after reset
rd_round_i  in  4  round index to read, 0..Nr
rd_key_o  out  128  round key; word 4r at [127:96], word 4r+3 at [31:0]

Behaviour:
- Reset (rst_i high at posedge): FSM=IDLE; busy_o, done_o, valid_o, err_o = 0; nr_o=0; rd_key_o=0 (RD_REG=1). Store contents not cleared. Reset mid-job aborts immediately with no done_o.
- Derived values: Nk=4/6/8, Nr=Nk+6, Nw=4*(Nr+1)=44/52/60.
- FSM states:
  - IDLE. On start_i with a legal keylen: latch keylen and key, clear valid_o, go to LOAD.
  - Rejected start: keylen=11 or Nk>MAX_NK. err_o pulses the next cycle, state stays IDLE, valid_o is unchanged.
  - LOAD (1 cycle): write w0..w(Nk-1) to the store; initialise an Nk-word sliding window; set i=Nk and rcon=8'h01; set nr_o.
  - EXPAND (Nw-Nk cycles): compute w[i] = w[i-Nk] ^ t, with t = w[i-1], except:
    - i mod Nk==0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon = xtime(rcon).
    - Nk==8 and i mod 8==4: t = SubWord(w[i-1]).
    - Each cycle: write w[i], shift the window, i++.
    - After writing w[Nw-1], go to DONE.
  - DONE (1 cycle): done_o=1, valid_o set to 1, busy_o=0, then IDLE.
- Latency: start accepted at edge k. done_o is high in cycle k+2+(Nw-Nk), i.e. 42/48/54 cycles after the start edge.
- start_i outside IDLE is ignored (no queuing, no error). start_i in the DONE cycle is ignored.
- A start accepted in IDLE while valid_o=1 starts a new job and clears valid_o.
- Read port:
  - rd_round_i > Nr, or nr_o=0: rd_key_o=0.
  - Reads during busy return the current store contents. These are not guaranteed coherent; consumers gate on valid_o.
  - RD_REG=1: rd_key_o reflects rd_round_i sampled at the previous edge.
- Store: MAX_NK-independent depth of 60 x 32 bits, write port 1 word/cycle. Can be flops or inferred RAM, provided the read port is asynchronous.

Decomposition:
- Package aes_ks_pkg:
  - keylen_t enum {AES128, AES192, AES256, KEY_ILLEGAL}
  - state_t enum {IDLE, LOAD, EXPAND, DONE}
  - nk_of()/nr_of() functions
  - xtime function
  - NW_MAX=60
- Sub-module aes_sbox_word: 4 parallel forward S-boxes, 32-bit in/out, combinational. Instantiated once; SubWord is never needed twice in one cycle.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c (MSB-aligned), start -> done_o exactly 42 cycles after start; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; nr_o=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_o at 48 cycles; round 12 = e98ba06f448c773c8ecc720401002202; rd_round_i=13 -> 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o at 54 cycles; round 14 = fe4890d1e6188d0b046df344706c631e; round 0 = 603deb1015ca71be2b73aef0857d7781.
- keylen_i=11 in IDLE -> err_o single pulse, busy_o stays 0, valid_o unchanged. With MAX_NK=4, keylen=AES256 -> err_o pulse.
- start_i held high through a whole AES-128 job -> exactly one job, one done_o pulse. A new AES-192 start after valid_o=1 -> valid_o drops the next cycle and rises at done_o.
- rst_i asserted at EXPAND cycle 20 -> next cycle busy_o=0, valid_o=0, nr_o=0, no done_o. A subsequent AES-128 job completes with correct keys.
